// File: rtl/iem_phase_align.sv
// Early/late data-eye tracker: integrates IEM LAG/LEAD over a window and nudges
// the input delay line one tap at a time to keep the sampling point centred.
module iem_phase_align #(
  parameter int WINDOW       = 64,
  parameter int THRESH       = 8,
  parameter int SETTLE       = 16,
  parameter int LOCK_WINDOWS = 4,
  parameter int MAX_TAP      = 127,
  parameter int INIT_TAP     = 64
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       lag_i,
  input  logic       lead_i,
  output logic       dly_step_o,
  output logic       dly_dir_o,
  output logic [6:0] tap_o,
  output logic       locked,
  output logic       at_limit_o,
  output logic [2:0] dbg_state_o
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int QW = $clog2(LOCK_WINDOWS + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_DECIDE = 3'd2,
    S_STEP   = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0] lead_cnt_q, lead_cnt_d;
  logic [CW-1:0] lag_cnt_q, lag_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [QW-1:0] quiet_cnt_q, quiet_cnt_d;
  logic [6:0]    tap_q, tap_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          locked_q, locked_d;
  logic          at_limit_q, at_limit_d;
  logic          lag_meta_q, lag_sync_q, lead_meta_q, lead_sync_q;
  int            diff;

  // LAG/LEAD come from the IEM without a timing relationship to clk.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      lag_meta_q  <= 1'b0;
      lag_sync_q  <= 1'b0;
      lead_meta_q <= 1'b0;
      lead_sync_q <= 1'b0;
    end else begin
      lag_meta_q  <= lag_i;
      lag_sync_q  <= lag_meta_q;
      lead_meta_q <= lead_i;
      lead_sync_q <= lead_meta_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = '0;
    lead_cnt_d   = '0;
    lag_cnt_d    = '0;
    settle_cnt_d = '0;
    quiet_cnt_d  = quiet_cnt_q;
    tap_d        = tap_q;
    step_d       = 1'b0;
    dir_d        = dir_q;
    at_limit_d   = at_limit_q;
    diff         = 32'(lead_cnt_q) - 32'(lag_cnt_q);

    case (state_q)
      S_IDLE: begin
        if (en_i) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        win_cnt_d  = win_cnt_q + CW'(1);
        lead_cnt_d = lead_cnt_q + CW'(lead_sync_q & ~lag_sync_q);
        lag_cnt_d  = lag_cnt_q + CW'(lag_sync_q & ~lead_sync_q);
        if (win_cnt_q == CW'(WINDOW - 1)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        state_d = S_SAMPLE;
        if ((diff >= THRESH && tap_q < 7'(MAX_TAP)) ||
            (-diff >= THRESH && tap_q > 7'd0)) begin
          state_d = S_STEP;
          step_d  = 1'b1;
          dir_d   = (diff >= THRESH);
        end else begin
          // A limit hit counts as a quiet window so the loop can still lock.
          at_limit_d = (diff >= THRESH) || (-diff >= THRESH);
          if (quiet_cnt_q != QW'(LOCK_WINDOWS)) quiet_cnt_d = quiet_cnt_q + QW'(1);
        end
      end
      S_STEP: begin
        tap_d       = dir_q ? tap_q + 7'd1 : tap_q - 7'd1;
        quiet_cnt_d = '0;
        at_limit_d  = 1'b0;
        state_d     = S_SETTLE;
      end
      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q + SW'(1);
        if (settle_cnt_q == SW'(SETTLE - 1)) state_d = S_SAMPLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Disabling wins over everything except a tap move already on its way out.
    if (!en_i) begin
      state_d     = S_IDLE;
      quiet_cnt_d = '0;
      step_d      = 1'b0;
    end

    locked_d = (quiet_cnt_d == QW'(LOCK_WINDOWS));
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      win_cnt_q    <= '0;
      lead_cnt_q   <= '0;
      lag_cnt_q    <= '0;
      settle_cnt_q <= '0;
      quiet_cnt_q  <= '0;
      tap_q        <= 7'(INIT_TAP);
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      locked_q     <= 1'b0;
      at_limit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      lead_cnt_q   <= lead_cnt_d;
      lag_cnt_q    <= lag_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      quiet_cnt_q  <= quiet_cnt_d;
      tap_q        <= tap_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      locked_q     <= locked_d;
      at_limit_q   <= at_limit_d;
    end
  end

  assign dly_step_o  = step_q;
  assign dly_dir_o   = dir_q;
  assign tap_o       = tap_q;
  assign locked      = locked_q;
  assign at_limit_o  = at_limit_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_iem_phase_align.sv
// Directed bench for iem_phase_align: default instance for tracking/lock/limit
// at MAX_TAP, second instance started at tap 2 for the lower limit.
module tb_iem_phase_align;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       en_a, lag_a, lead_a, en_b, lag_b, lead_b;
  logic       step_a, dir_a, locked_a, lim_a, step_b, dir_b, locked_b, lim_b;
  logic [6:0] tap_a, tap_b;
  logic [2:0] st_a, st_b;

  int cyc = 0;
  int e0 = 0;
  int checks = 0;
  int passed = 0;
  int inc_a = 0, dec_a = 0, dbl_a = 0, inc_b = 0, dec_b = 0, dbl_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int base_inc, base_dec, base_dbl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_STEP = 3'd3, ST_SETTLE = 3'd4;

  iem_phase_align dut_a (
    .clk(clk), .rst_i(rst_i), .en_i(en_a), .lag_i(lag_a), .lead_i(lead_a),
    .dly_step_o(step_a), .dly_dir_o(dir_a), .tap_o(tap_a), .locked(locked_a),
    .at_limit_o(lim_a), .dbg_state_o(st_a)
  );

  iem_phase_align #(.INIT_TAP(2)) dut_b (
    .clk(clk), .rst_i(rst_i), .en_i(en_b), .lag_i(lag_b), .lead_i(lead_b),
    .dly_step_o(step_b), .dly_dir_o(dir_b), .tap_o(tap_b), .locked(locked_b),
    .at_limit_o(lim_b), .dbg_state_o(st_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor: counts pulses per direction and back-to-back highs
  always @(negedge clk) begin
    if (step_a) begin
      if (dir_a) inc_a++; else dec_a++;
      if (prev_a) dbl_a++;
    end
    if (step_b) begin
      if (dir_b) inc_b++; else dec_b++;
      if (prev_b) dbl_b++;
    end
    prev_a = step_a;
    prev_b = step_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // advance to 1 time unit after edge e0+k (e0 = edge count when en rose)
  task automatic goto_cyc(input int k);
    while (cyc - e0 < k) begin @(posedge clk); #1; end
  endtask

  task automatic start_a;
    en_a = 1'b1;
    e0 = cyc;
  endtask

  initial begin
    rst_i = 1'b0;
    en_a = 0; lag_a = 0; lead_a = 0;
    en_b = 0; lag_b = 0; lead_b = 0;
    wait_edges(3);
    check("rst_tap_a", 32'(tap_a), 64);
    check("rst_tap_b", 32'(tap_b), 2);
    check("rst_step", 32'(step_a), 0);
    check("rst_dir", 32'(dir_a), 0);
    check("rst_locked", 32'(locked_a), 0);
    check("rst_limit", 32'(lim_a), 0);
    check("rst_state", 32'(st_a), 32'(ST_IDLE));
    rst_i = 1'b1;
    wait_edges(1);

    // quiet input locks after four no-step windows
    base_inc = inc_a; base_dec = dec_a;
    start_a();
    goto_cyc(258);
    check("quiet_locked_early", 32'(locked_a), 0);
    goto_cyc(264);
    check("quiet_locked", 32'(locked_a), 1);
    check("quiet_tap", 32'(tap_a), 64);
    check("quiet_pulses", 32'(inc_a + dec_a - base_inc - base_dec), 0);

    // disable: idle, unlocked, tap held
    en_a = 1'b0;
    wait_edges(2);
    check("dis_state", 32'(st_a), 32'(ST_IDLE));
    check("dis_locked", 32'(locked_a), 0);
    check("dis_tap", 32'(tap_a), 64);

    // d = 10 - 5 = 5 below threshold: no step, window counts as quiet
    base_inc = inc_a; base_dec = dec_a;
    start_a();
    goto_cyc(9);  lead_a = 1'b1;
    goto_cyc(19); lead_a = 1'b0;
    goto_cyc(29); lag_a = 1'b1;
    goto_cyc(34); lag_a = 1'b0;
    goto_cyc(67);
    check("d5_pulses", 32'(inc_a + dec_a - base_inc - base_dec), 0);
    check("d5_tap", 32'(tap_a), 64);
    goto_cyc(264);
    check("d5_locked", 32'(locked_a), 1);

    // d = 13 - 5 = 8 exactly: one increment step
    en_a = 1'b0;
    wait_edges(2);
    start_a();
    goto_cyc(9);  lead_a = 1'b1;
    goto_cyc(22); lead_a = 1'b0;
    goto_cyc(29); lag_a = 1'b1;
    goto_cyc(34); lag_a = 1'b0;
    goto_cyc(66);
    check("d8_step", 32'(step_a), 1);
    check("d8_dir", 32'(dir_a), 1);
    check("d8_state", 32'(st_a), 32'(ST_STEP));
    check("d8_tap_before", 32'(tap_a), 64);
    goto_cyc(67);
    check("d8_step_off", 32'(step_a), 0);
    check("d8_tap_after", 32'(tap_a), 65);
    check("d8_settle", 32'(st_a), 32'(ST_SETTLE));

    // drop enable mid-SETTLE
    goto_cyc(70); en_a = 1'b0;
    goto_cyc(71);
    check("settle_dis_state", 32'(st_a), 32'(ST_IDLE));
    check("settle_dis_locked", 32'(locked_a), 0);
    check("settle_dis_tap", 32'(tap_a), 65);

    // lag and lead both high for a whole window: nothing counted
    lag_a = 1'b1; lead_a = 1'b1;
    wait_edges(3);
    base_inc = inc_a; base_dec = dec_a;
    start_a();
    goto_cyc(70);
    check("both_pulses", 32'(inc_a + dec_a - base_inc - base_dec), 0);
    check("both_tap", 32'(tap_a), 65);
    check("both_limit", 32'(lim_a), 0);
    en_a = 1'b0; lag_a = 1'b0;
    wait_edges(3);

    // reset asserted while the step pulse is high
    start_a();
    goto_cyc(66);
    check("rststep_pulse", 32'(step_a), 1);
    #2 rst_i = 1'b0;
    #1;
    check("rststep_step", 32'(step_a), 0);
    check("rststep_tap", 32'(tap_a), 64);
    check("rststep_state", 32'(st_a), 32'(ST_IDLE));
    en_a = 1'b0;
    wait_edges(1);
    rst_i = 1'b1;
    wait_edges(2);

    // lead held high: 63 increments to MAX_TAP, then limit and lock
    base_inc = inc_a; base_dec = dec_a; base_dbl = dbl_a;
    start_a();
    goto_cyc(66);
    check("lead_first_step", 32'(step_a), 1);
    check("lead_first_dir", 32'(dir_a), 1);
    goto_cyc(67);
    check("lead_first_tap", 32'(tap_a), 65);
    goto_cyc(147);
    check("lead_gap", 32'(step_a), 0);
    goto_cyc(148);
    check("lead_second_step", 32'(step_a), 1);
    goto_cyc(149);
    check("lead_second_tap", 32'(tap_a), 66);
    goto_cyc(5151);
    check("lead_tap_max", 32'(tap_a), 127);
    goto_cyc(5233);
    check("lead_at_limit", 32'(lim_a), 1);
    check("lead_tap_hold", 32'(tap_a), 127);
    goto_cyc(5424);
    check("lead_locked_early", 32'(locked_a), 0);
    goto_cyc(5430);
    check("lead_locked", 32'(locked_a), 1);
    check("lead_inc_count", 32'(inc_a - base_inc), 63);
    check("lead_dec_count", 32'(dec_a - base_dec), 0);
    check("lead_no_double", 32'(dbl_a - base_dbl), 0);
    en_a = 1'b0; lead_a = 1'b0;

    // lag held high from tap 2: two decrements to 0, then limit and lock
    lag_b = 1'b1;
    wait_edges(3);
    en_b = 1'b1;
    e0 = cyc;
    goto_cyc(66);
    check("lag_first_step", 32'(step_b), 1);
    check("lag_first_dir", 32'(dir_b), 0);
    goto_cyc(67);
    check("lag_first_tap", 32'(tap_b), 1);
    goto_cyc(148);
    check("lag_second_step", 32'(step_b), 1);
    goto_cyc(149);
    check("lag_second_tap", 32'(tap_b), 0);
    goto_cyc(231);
    check("lag_at_limit", 32'(lim_b), 1);
    check("lag_tap_zero", 32'(tap_b), 0);
    goto_cyc(422);
    check("lag_locked_early", 32'(locked_b), 0);
    goto_cyc(428);
    check("lag_locked", 32'(locked_b), 1);
    check("lag_dec_count", 32'(dec_b), 2);
    check("lag_inc_count", 32'(inc_b), 0);
    check("lag_no_double", 32'(dbl_b), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/iem_phase_align.md
# iem_phase_align

Closed-loop data-eye alignment controller for a deserialising input lane. It monitors the LAG/LEAD outputs of the lane's IEM early/late monitor and accumulates them over a fixed sampling window. At the end of each window it issues single-tap increment/decrement commands to the lane's input delay line, so the IDDR sampling point stays centred. It runs in the fabric `clk` domain, next to the IDDR/IEM pair it serves, and raises `locked` once the phase has been stable for several windows.

## Interface

Parameters:
- `WINDOW`, 64: number of `clk` cycles per sampling window (≥ 4).
- `THRESH`, 8: minimum |lead_cnt − lag_cnt| that triggers a tap step.
- `SETTLE`, 16: cycles to wait after a step before sampling again (≥ 1).
- `LOCK_WINDOWS`, 4: consecutive no-step windows required for `locked`.
- `MAX_TAP`, 127: highest legal delay tap. Taps are 7 bits wide.
- `INIT_TAP`, 64: tap value loaded at reset.

Ports:
- `clk`, input, 1: fabric clock. This is the same clock that drives IEM `MCLK`.
- `rst_i`, input, 1: asynchronous, active-low reset.
- `en_i`, input, 1: enables tracking. When low, the block idles and holds its tap.
- `lag_i`, input, 1: IEM LAG. Asynchronous to `clk`.
- `lead_i`, input, 1: IEM LEAD. Asynchronous to `clk`.
- `dly_step_o`, output, 1: one-cycle pulse that commands a single tap move.
- `dly_dir_o`, output, 1: step direction. 1 = increment (more delay), 0 = decrement. Valid whenever `dly_step_o` = 1.
- `tap_o`, output, 7: current tap value, as tracked by this block.
- `locked`, output, 1: phase stable.
- `at_limit_o`, output, 1: a step was wanted, but the tap is at 0 or `MAX_TAP`.

## Operation

- `lag_i` and `lead_i` each pass through a 2-FF synchroniser before any use.
- Counting: each cycle in SAMPLE is classified from the synchronised values.
  - lead only: `lead_cnt`++.
  - lag only: `lag_cnt`++.
  - both high, or neither: no count.
  - Counter width is clog2(WINDOW+1), so the counters cannot overflow.
- States: IDLE, SAMPLE, DECIDE, STEP, SETTLE.
- IDLE:
  - Outputs hold.
  - Transitions to SAMPLE when `en_i` = 1. Both counters and the window counter are cleared on entry to SAMPLE.
- SAMPLE:
  - Counts for exactly `WINDOW` cycles, then moves to DECIDE.
- DECIDE (1 cycle), with d = lead_cnt − lag_cnt (signed):
  - d ≥ THRESH and tap < MAX_TAP: want increment. Move to STEP.
  - −d ≥ THRESH and tap > 0: want decrement. Move to STEP.
  - Threshold met but tap at the corresponding limit:
    - set `at_limit_o` = 1;
    - treat the window as a no-step window;
    - go to SAMPLE.
  - Otherwise (threshold not met):
    - clear `at_limit_o`;
    - quiet_cnt++ (saturating at LOCK_WINDOWS);
    - go to SAMPLE.
- STEP (1 cycle):
  - `dly_step_o` = 1, with `dly_dir_o` set to the chosen direction.
  - `tap_o` updates by ±1 on the same edge that ends STEP.
  - quiet_cnt ← 0, `locked` ← 0, `at_limit_o` ← 0.
  - Then SETTLE.
- SETTLE:
  - Waits `SETTLE` cycles with counting disabled, then returns to SAMPLE.
- `locked` = 1 while quiet_cnt == LOCK_WINDOWS.
  - A limit-hit window still increments quiet_cnt.
  - Only an actual step clears `locked`.
- `en_i` falling in any state:
  - Next state is IDLE. Counters are discarded.
  - `locked` ← 0, quiet_cnt ← 0.
  - `tap_o` and `at_limit_o` hold.
  - If `en_i` falls during STEP, that step's pulse and tap update complete, since they occur in the same cycle.
- `tap_o` never leaves the range [0, MAX_TAP].

## Timing

- Reset values (asynchronous, while `rst_i` = 0):
  - state = IDLE;
  - `tap_o` = INIT_TAP;
  - `dly_step_o` = 0, `dly_dir_o` = 0, `locked` = 0, `at_limit_o` = 0;
  - all counters and synchroniser flops = 0.
- Reset may assert mid-window or mid-step. Any pulse in flight is truncated, and outputs go to their reset values immediately.
- Input latency: an IEM edge affects the counters 2 cycles later (synchroniser delay).
- Cycle cost per window:
  - step window: WINDOW + 1 (DECIDE) + 1 (STEP) + SETTLE cycles;
  - no-step window: WINDOW + 1 cycles.
- `dly_step_o` is never high on two consecutive cycles. The minimum spacing between pulses is WINDOW + SETTLE + 2 cycles.
- Earliest `locked` after `en_i` rises: 2 + LOCK_WINDOWS × (WINDOW + 1) cycles, assuming quiet input.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan

1. Reset with `en_i` = 1 and lag = lead = 0:
   - `tap_o` stays at 64 and `dly_step_o` is never asserted;
   - `locked` rises at cycle 2 + 4×65 = 262 after `en_i` rises, ±1 cycle.
2. `lead_i` held high, with defaults:
   - the first `dly_step_o` pulse comes with `dly_dir_o` = 1 at cycle ~67;
   - `tap_o` becomes 65;
   - pulses then repeat every 82 cycles;
   - `tap_o` reaches 127 after 63 steps, then `at_limit_o` = 1 and no further pulses occur.
3. `lag_i` held high from INIT_TAP = 2:
   - two decrement pulses take `tap_o` to 0;
   - `at_limit_o` then rises, and `locked` rises after 4 further windows.
4. lead high for 10 cycles and lag high for 5 cycles in one window (d = 5 < 8):
   - no step occurs and quiet_cnt advances;
   - with d = 8 exactly, one increment step occurs.
5. lag and lead both high for a whole window: no counts and no step.
6. Mid-operation disturbances:
   - deasserting `en_i` during SETTLE gives IDLE next cycle, `locked` = 0, and `tap_o` held;
   - pulling `rst_i` low during STEP clears `dly_step_o` asynchronously and restores `tap_o` to 64.
